// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine between the 6502 bus outputs and the CPU-side mapper.
// A write to DMA_REG_ADDR halts the CPU and copies one 256-byte page into OAMDATA.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic        bus_we,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        dma_active
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  rd_latch_q, rd_latch_d;
    logic        cyc_odd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= 8'h00;
            page_q     <= 8'h00;
            rd_latch_q <= 8'h00;
            cyc_odd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            page_q     <= page_d;
            rd_latch_q <= rd_latch_d;
            cyc_odd_q  <= ~cyc_odd_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        page_d     = page_q;
        rd_latch_d = rd_latch_q;
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        bus_addr   = cpu_addr;
        bus_we     = cpu_we;
        bus_wdata  = cpu_wdata;

        case (state_q)
            IDLE: begin
                // The trigger write still reaches the mapper unchanged.
                if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
                    page_d     = cpu_wdata;
                    byte_cnt_d = 8'h00;
                    state_d    = HALT;
                end
            end
            HALT: begin
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                bus_we     = 1'b0;
                bus_wdata  = rd_latch_q;
                // Reads must land on the even half of the CPU cycle pair.
                state_d    = cyc_odd_q ? ALIGN : READ;
            end
            ALIGN: begin
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                bus_we     = 1'b0;
                bus_wdata  = rd_latch_q;
                state_d    = READ;
            end
            READ: begin
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                bus_addr   = {page_q, byte_cnt_q};
                bus_we     = 1'b0;
                bus_wdata  = rd_latch_q;
                rd_latch_d = bus_rdata;
                state_d    = WRITE;
            end
            WRITE: begin
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                bus_addr   = OAMDATA_ADDR;
                bus_we     = 1'b1;
                bus_wdata  = rd_latch_q;
                byte_cnt_d = byte_cnt_q + 8'd1;
                state_d    = (byte_cnt_q == 8'hFF) ? IDLE : READ;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl: a mapper memory model plus a per-cycle
// reference trace of what a DMA transfer must put on the bus.
module tb_oam_dma_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        dma_active;

    logic [7:0]  mem [0:65535];
    int          total;
    int          bad;
    int          cyc;
    int          trig_cyc;

    oam_dma_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdy    (cpu_rdy),
        .bus_addr   (bus_addr),
        .bus_we     (bus_we),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .dma_active (dma_active)
    );

    assign bus_rdata = mem[bus_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since the last reset edge; its parity is the CPU cycle parity.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic test_reset();
        reset = 1'b1; cpu_addr = 16'h0000; cpu_we = 1'b0; cpu_wdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: cpu_rdy=%b dma_active=%b expected 1/0", cpu_rdy, dma_active);
        end
        @(posedge clk); #1;
        reset = 1'b0; cpu_addr = 16'h8000; cpu_we = 1'b0; cpu_wdata = 8'h33;
        @(negedge clk);
        total++;
        if (bus_addr !== 16'h8000 || bus_we !== 1'b0 || cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
            bad++; $display("FAIL read_8000: addr=%h we=%b rdy=%b act=%b expected 8000/0/1/0", bus_addr, bus_we, cpu_rdy, dma_active);
        end
        @(posedge clk); #1;
        cpu_addr = 16'h0010; cpu_we = 1'b1; cpu_wdata = 8'h5A;
        @(negedge clk);
        total++;
        if (bus_addr !== 16'h0010 || bus_we !== 1'b1 || bus_wdata !== 8'h5A || cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
            bad++; $display("FAIL write_0010: addr=%h we=%b data=%h rdy=%b act=%b expected 0010/1/5a/1/0", bus_addr, bus_we, bus_wdata, cpu_rdy, dma_active);
        end
    endtask

    task automatic test_passthrough();
        int errs = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            cpu_addr  = 16'($urandom_range(0, 65535));
            if (cpu_addr == 16'h4014) cpu_addr = 16'h4015;
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_wdata = 8'($urandom_range(0, 255));
            @(negedge clk);
            if (bus_addr !== cpu_addr || bus_we !== cpu_we || bus_wdata !== cpu_wdata || cpu_rdy !== 1'b1 || dma_active !== 1'b0) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL passthrough_random: mismatching cycles=%0d expected 0", errs);
        end
        // A read of $4014 and writes elsewhere must not start a transfer.
        @(posedge clk); #1;
        cpu_addr = 16'h4014; cpu_we = 1'b0; cpu_wdata = 8'h02;
        @(posedge clk); #1;
        cpu_addr = 16'h4015; cpu_we = 1'b1;
        @(posedge clk); #1;
        cpu_addr = 16'h8000; cpu_we = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
            bad++; $display("FAIL no_false_trigger: cpu_rdy=%b dma_active=%b expected 1/0", cpu_rdy, dma_active);
        end
    endtask

    // Drives the trigger write in a cycle chosen so the transfer does (or does not) need alignment.
    task automatic issue_trigger(input logic [7:0] page, input bit want_align);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            cpu_addr = 16'h8000; cpu_we = 1'b0;
            if (((cyc + 1) & 1) == int'(want_align)) break;
        end
        cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_wdata = page;
        @(negedge clk);
        trig_cyc = cyc;
        total++;
        if (bus_addr !== 16'h4014 || bus_we !== 1'b1 || bus_wdata !== page || cpu_rdy !== 1'b1) begin
            bad++; $display("FAIL trigger_passthrough: addr=%h we=%b data=%h rdy=%b expected 4014/1/%h/1", bus_addr, bus_we, bus_wdata, cpu_rdy, page);
        end
    endtask

    // Follows one transfer from the cycle after its trigger until cpu_rdy returns.
    task automatic run_dma(input string name, input logic [7:0] page, input logic [15:0] hold,
                           input bit b2b, input logic [7:0] page2, output logic [7:0] last_w);
        logic [15:0] ea[$];
        logic        ew[$];
        logic [7:0]  ed[$];
        logic [15:0] oa[$];
        logic        ow[$];
        logic [7:0]  od[$];
        int extra, n, mism, first_bad, nw, act_err;
        bit done;
        extra = (trig_cyc + 1) & 1;
        for (int i = 0; i < 1 + extra; i++) begin
            ea.push_back(hold); ew.push_back(1'b0); ed.push_back(8'h00);
        end
        for (int i = 0; i < 256; i++) begin
            ea.push_back({page, 8'(i)}); ew.push_back(1'b0); ed.push_back(8'h00);
            ea.push_back(16'h2004);      ew.push_back(1'b1); ed.push_back(mem[{page, 8'(i)}]);
        end
        n = 0; done = 1'b0; act_err = 0; last_w = 8'h00;
        while (!done && n < 600) begin
            @(posedge clk); #1;
            cpu_addr = hold;
            if (b2b) begin
                cpu_we = 1'b1; cpu_wdata = page2;
            end else begin
                cpu_we = 1'($urandom_range(0, 1)); cpu_wdata = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            if (cpu_rdy === 1'b1) begin
                done = 1'b1;
            end else begin
                n++;
                oa.push_back(bus_addr); ow.push_back(bus_we); od.push_back(bus_wdata);
                if (dma_active !== 1'b1) act_err++;
            end
        end
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL %s_timeout: cpu_rdy never returned within 600 cycles", name);
        end
        total++;
        if (n !== 513 + extra) begin
            bad++; $display("FAIL %s_stall_len: got %0d cycles expected %0d", name, n, 513 + extra);
        end
        mism = (oa.size() != ea.size()) ? 1 : 0;
        first_bad = -1; nw = 0;
        for (int i = 0; i < oa.size(); i++) begin
            if (ow[i] === 1'b1) begin
                nw++;
                last_w = od[i];
            end
            if (i < ea.size()) begin
                if (oa[i] !== ea[i] || ow[i] !== ew[i] || (ew[i] && od[i] !== ed[i])) begin
                    mism++;
                    if (first_bad < 0) first_bad = i;
                end
            end
        end
        total++;
        if (mism !== 0) begin
            bad++;
            if (first_bad >= 0)
                $display("FAIL %s_trace: %0d bad cycles, first at %0d got addr=%h we=%b data=%h expected addr=%h we=%b data=%h",
                         name, mism, first_bad, oa[first_bad], ow[first_bad], od[first_bad], ea[first_bad], ew[first_bad], ed[first_bad]);
            else
                $display("FAIL %s_trace: trace length %0d expected %0d", name, oa.size(), ea.size());
        end
        total++;
        if (nw !== 256) begin
            bad++; $display("FAIL %s_write_count: got %0d writes expected 256", name, nw);
        end
        total++;
        if (oa.size() <= 1 + extra || oa[1 + extra] !== {page, 8'h00}) begin
            bad++; $display("FAIL %s_first_read: got %h expected %h", name, (oa.size() > 1 + extra) ? oa[1 + extra] : 16'hxxxx, {page, 8'h00});
        end
        total++;
        if (act_err !== 0) begin
            bad++; $display("FAIL %s_dma_active: low in %0d stalled cycles expected 0", name, act_err);
        end
        total++;
        if (dma_active !== 1'b0 || bus_addr !== cpu_addr || bus_we !== cpu_we || bus_wdata !== cpu_wdata) begin
            bad++; $display("FAIL %s_release: act=%b addr=%h we=%b data=%h expected 0/%h/%b/%h",
                            name, dma_active, bus_addr, bus_we, bus_wdata, cpu_addr, cpu_we, cpu_wdata);
        end
        trig_cyc = cyc;
    endtask

    task automatic test_dma_no_align();
        logic [7:0] lw;
        issue_trigger(8'h02, 1'b0);
        run_dma("even", 8'h02, 16'h8000, 1'b0, 8'h00, lw);
    endtask

    task automatic test_dma_align();
        logic [7:0] lw;
        issue_trigger(8'h02, 1'b1);
        run_dma("odd", 8'h02, 16'h8000, 1'b0, 8'h00, lw);
    endtask

    task automatic test_page_ff();
        logic [7:0] lw;
        issue_trigger(8'hFF, 1'($urandom_range(0, 1)));
        run_dma("page_ff", 8'hFF, 16'hC123, 1'b0, 8'h00, lw);
        total++;
        if (lw !== (8'hFF ^ 8'hA5)) begin
            bad++; $display("FAIL page_ff_last_byte: got %h expected %h", lw, 8'hFF ^ 8'hA5);
        end
    endtask

    task automatic test_random_pages();
        logic [7:0] lw;
        logic [7:0] pg;
        for (int r = 0; r < 3; r++) begin
            pg = 8'($urandom_range(0, 255));
            issue_trigger(pg, 1'($urandom_range(0, 1)));
            run_dma("rand_page", pg, 16'h9000, 1'b0, 8'h00, lw);
        end
    endtask

    task automatic test_reset_mid();
        int extra, target, wcnt, derr;
        issue_trigger(8'h02, 1'($urandom_range(0, 1)));
        extra  = (trig_cyc + 1) & 1;
        target = 1 + extra + 2 * 39 + 1;
        wcnt = 0; derr = 0;
        for (int idx = 0; idx <= target; idx++) begin
            @(posedge clk); #1;
            cpu_addr = 16'h8000; cpu_we = 1'b0;
            if (idx == target) reset = 1'b1;
            @(negedge clk);
            if (reset === 1'b0 && bus_we === 1'b1 && dma_active === 1'b1) begin
                if (bus_addr !== 16'h2004 || bus_wdata !== mem[16'h0200 + wcnt]) derr++;
                wcnt++;
            end
        end
        total++;
        if (bus_we !== 1'b1 || bus_addr !== 16'h2004) begin
            bad++; $display("FAIL reset_mid_40th_write: we=%b addr=%h expected 1/2004", bus_we, bus_addr);
        end
        @(posedge clk); #1;
        reset = 1'b0; cpu_addr = 16'h0300; cpu_we = 1'b1; cpu_wdata = 8'h77;
        @(negedge clk);
        total++;
        if (cpu_rdy !== 1'b1 || dma_active !== 1'b0 || bus_we !== 1'b1 || bus_addr !== 16'h0300 || bus_wdata !== 8'h77) begin
            bad++; $display("FAIL reset_mid_idle: rdy=%b act=%b we=%b addr=%h data=%h expected 1/0/1/0300/77",
                            cpu_rdy, dma_active, bus_we, bus_addr, bus_wdata);
        end
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 16'h8000;
        @(negedge clk);
        total++;
        if (bus_we !== 1'b0 || cpu_rdy !== 1'b1) begin
            bad++; $display("FAIL reset_mid_no_write: we=%b rdy=%b expected 0/1", bus_we, cpu_rdy);
        end
        total++;
        if (wcnt !== 39 || derr !== 0) begin
            bad++; $display("FAIL reset_mid_count: writes=%0d data_errors=%0d expected 39/0", wcnt, derr);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] lw;
        logic [7:0] pg2;
        pg2 = 8'($urandom_range(3, 254));
        issue_trigger(8'h02, 1'($urandom_range(0, 1)));
        run_dma("b2b_first", 8'h02, 16'h4014, 1'b1, pg2, lw);
        run_dma("b2b_second", pg2, 16'h8000, 1'b0, 8'h00, lw);
    endtask

    initial begin
        total = 0; bad = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i);
            mem[16'hFF00 + i] = 8'(i) ^ 8'hA5;
        end
        test_reset();
        test_passthrough();
        test_dma_no_align();
        test_dma_align();
        test_page_ff();
        test_random_pages();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- OAM DMA engine sitting directly upstream of the CPU-side memory mapper, between the 6502 core's bus outputs and the mapper's address/WE/data inputs.
- On a CPU write to $4014 it stalls the CPU and takes ownership of the bus.
- It copies 256 bytes from CPU page $XX00-$XXFF into PPU OAM by alternating mapper reads with writes to $2004 (OAMDATA).
- When idle it is a transparent pass-through of the CPU bus.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address whose write triggers DMA.
- OAMDATA_ADDR, 16'h2004, destination address driven on every DMA write cycle.

Ports:
- clk  in  1  system clock; one rising edge = one CPU cycle.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU core address.
- cpu_we  in  1  CPU core write strobe, active high.
- cpu_wdata  in  8  CPU core write data.
- cpu_rdy  out  1  1 = CPU may advance; 0 = CPU halted.
- bus_addr  out  16  address to mapper.
- bus_we  out  1  write enable to mapper.
- bus_wdata  out  8  write data to mapper data_in.
- bus_rdata  in  8  mapper data_out (read data for the current bus_addr, valid same cycle).
- dma_active  out  1  high while the engine owns the bus.

Behaviour:
- Cycle parity:
  - cyc_odd flop, reset 0, toggles every clk.
- Reset values:
  - cpu_rdy=1, dma_active=0, state=IDLE, byte_cnt=0, page=0, rd_latch=0.
  - In IDLE, bus outputs equal the CPU inputs.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - Bus mux: bus_addr=cpu_addr, bus_we=cpu_we, bus_wdata=cpu_wdata.
  - Trigger: cpu_we && cpu_addr==DMA_REG_ADDR. The trigger write itself passes through to the mapper unchanged.
  - On trigger: page<=cpu_wdata, byte_cnt<=0, next=HALT.
- HALT (1 cycle):
  - cpu_rdy=0, dma_active=1, bus_we=0, bus_addr=cpu_addr.
  - Next = ALIGN if cyc_odd==1 in this cycle, else READ.
- ALIGN (1 cycle):
  - Same outputs as HALT. Next = READ.
- READ:
  - bus_addr={page,byte_cnt}, bus_we=0.
  - rd_latch<=bus_rdata at the closing edge.
  - Next = WRITE.
- WRITE:
  - bus_addr=OAMDATA_ADDR, bus_we=1, bus_wdata=rd_latch.
  - byte_cnt<=byte_cnt+1 (8-bit).
  - If byte_cnt==8'hFF: next=IDLE; else next=READ.
- DMA states (HALT, ALIGN, READ, WRITE):
  - cpu_rdy=0 and dma_active=1 throughout.
  - cpu_we and cpu_wdata are ignored.
- Latency and length:
  - cpu_rdy falls the cycle after the trigger write.
  - cpu_rdy rises in the cycle after the final WRITE.
  - Total stall: 513 cycles (HALT + 512), or 514 with ALIGN.
- Boundaries:
  - byte_cnt wraps FF->00 exactly at completion; the source address never carries into page.
  - Page $FF reads $FF00-$FFFF.
  - Page $20-$3F reads PPU registers; no special handling.
  - A $4014 write on the cycle DMA completes (state WRITE) is impossible because the CPU is halted.
  - The first IDLE cycle after completion may retrigger a DMA.
  - Reset mid-transfer: next cycle is IDLE with reset values. No further bus_we; OAM is partially written, which is acceptable.
- Outputs are combinational from state and registers; no extra pipeline stage.

Test Plan:
- Reset, then CPU read of $8000 and write of $0010=8'h5A -> bus mirrors the CPU exactly, cpu_rdy=1, dma_active=0.
- Preload $0200-$02FF with value=index; write 8'h02 to $4014 on an even cycle -> 513 stalled cycles; 256 writes to $2004 with data 00..FF in order; cpu_rdy returns high on cycle 514.
- Same trigger issued on an odd cycle -> one ALIGN cycle; 514 stalled; first READ address $0200; data sequence unchanged.
- Page 8'hFF with ROM pattern -> reads $FF00..$FFFF; last write carries the $FFFF byte; no access to $0000.
- Assert reset on the 40th WRITE -> next cycle IDLE, cpu_rdy=1, bus_we follows cpu_we; exactly 39 DMA writes were observed before reset.
- Back-to-back: a new $4014 write on the first cycle after completion -> a second DMA starts correctly with the new page value.
